// File: rtl/controller_emulator.sv
// rtl/controller_emulator.sv - APB3 game-pad emulator that shifts a button image out on latch/pulse
module controller_emulator #(
  parameter int NUM_BITS   = 8,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        poll,
  input  logic        pulse,
  output logic        data
);

  // Counter must hold the value NUM_BITS itself, which marks "exhausted".
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(NUM_BITS);

  localparam logic [1:0] OFS_BUTTONS = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_CTRL    = 2'd2;
  localparam logic [1:0] OFS_UNUSED  = 2'd3;

  // Console-side inputs: two synchroniser flops plus one history flop each.
  logic poll_s1, poll_s2, poll_s3;
  logic pulse_s1, pulse_s2, pulse_s3;
  logic poll_level, poll_rise, pulse_rise;

  // Software-visible state.
  logic [NUM_BITS-1:0] buttons;
  logic                enable;
  logic [7:0]          latch_count;

  // Shift engine.
  logic [NUM_BITS-1:0] shreg;
  logic [CW-1:0]       cnt;
  logic                shifting;
  logic                busy;

  // APB decode.
  logic       access;
  logic       wr;
  logic [1:0] ofs;
  logic [31:0] rdata_mux;

  // Address and data bits this slave ignores.
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:NUM_BITS]};

  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign ofs    = PADDR[3:2];

  assign poll_level = poll_s2;
  assign poll_rise  = poll_s2 & ~poll_s3;
  assign pulse_rise = pulse_s2 & ~pulse_s3;

  assign shifting = (cnt < CNT_DONE);
  assign busy     = enable & shifting & ~poll_level;

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (ofs == OFS_UNUSED);
  assign PRDATA  = rdata_mux;

  // Bring poll and pulse into the PCLK domain and keep one cycle of history for edges.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      poll_s1  <= 1'b0;
      poll_s2  <= 1'b0;
      poll_s3  <= 1'b0;
      pulse_s1 <= 1'b0;
      pulse_s2 <= 1'b0;
      pulse_s3 <= 1'b0;
    end else begin
      poll_s1  <= poll;
      poll_s2  <= poll_s1;
      poll_s3  <= poll_s2;
      pulse_s1 <= pulse;
      pulse_s2 <= pulse_s1;
      pulse_s3 <= pulse_s2;
    end
  end

  // Register writes and the latch counter; a clearing write beats a coincident poll rise.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      buttons     <= '0;
      enable      <= 1'b0;
      latch_count <= 8'd0;
    end else begin
      if (wr && ofs == OFS_BUTTONS) begin
        buttons <= PWDATA[NUM_BITS-1:0];
      end
      if (wr && ofs == OFS_CTRL) begin
        enable <= PWDATA[0];
      end
      if (wr && ofs == OFS_STATUS) begin
        latch_count <= 8'd0;
      end else if (poll_rise) begin
        latch_count <= latch_count + 8'd1;
      end
    end
  end

  // Load while latched, otherwise shift right on each pulse until the image is exhausted.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      shreg <= '0;
      cnt   <= CNT_DONE;
    end else if (poll_level) begin
      shreg <= buttons;
      cnt   <= '0;
    end else if (pulse_rise && shifting) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

  // Registered serial output, active-low; idle level when disabled or exhausted.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data <= 1'b1;
    end else if (!enable) begin
      data <= IDLE_LEVEL;
    end else if (shifting) begin
      data <= ~shreg[0];
    end else begin
      data <= IDLE_LEVEL;
    end
  end

  // Read mux, driven only during the access phase.
  always_comb begin
    rdata_mux = 32'd0;
    if (access) begin
      case (ofs)
        OFS_BUTTONS: rdata_mux = 32'(buttons);
        OFS_STATUS:  rdata_mux = {16'd0, latch_count, 7'd0, busy};
        OFS_CTRL:    rdata_mux = {31'd0, enable};
        default:     rdata_mux = 32'd0;
      endcase
    end
  end

endmodule
